pc_ras_unit: RTL
================

Name: pc_ras_unit

Overview:
Parametrised program counter for the RAT CPU with an integrated next-address mux and a hardware return-address stack (RAS).
- Generalises the fixed 10-bit PC/PC_MUX pair to arbitrary address width.
- Adds an interrupt-vector source and a circular RAS for CALL/RET.
- Sits between the control unit (select, load, increment and push/pop strobes) and the program ROM address input.

Parameters:
ADDR_W, 10, PC and all address-path width.
RAS_DEPTH, 8, number of RAS entries (>=2).
INTR_VEC, all ones (10'h3FF at default), value loaded for PC_MUX_SEL=3.
RST_VAL, 0, PC value after reset.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous, active-high reset.
FROM_IMMED  in  ADDR_W  branch/call target from the instruction.
FROM_STACK  in  ADDR_W  address popped from the data-memory stack.
PC_MUX_SEL  in  2  0=IMMED, 1=STACK, 2=RAS top, 3=INTR_VEC.
PC_LD  in  1  load the mux output into the PC.
PC_INC  in  1  increment the PC.
RAS_PUSH  in  1  push PC_COUNT+1 onto the RAS.
RAS_POP  in  1  pop the RAS.
PC_COUNT  out  ADDR_W  current PC (registered).
RAS_TOP  out  ADDR_W  current top entry; 0 when empty (combinational from storage).
RAS_COUNT  out  $clog2(RAS_DEPTH+1)  valid entries.
RAS_EMPTY  out  1  RAS_COUNT==0.
RAS_FULL  out  1  RAS_COUNT==RAS_DEPTH.
RAS_OVF  out  1  sticky overflow flag.
RAS_UNF  out  1  sticky underflow flag.

Behaviour:
- Reset (synchronous, highest priority; all other inputs ignored that cycle):
  - PC_COUNT=RST_VAL, RAS_COUNT=0, RAS_OVF=0, RAS_UNF=0.
  - RAS_TOP=0, RAS_EMPTY=1, RAS_FULL=0.
- PC update on each rising edge, priority RST > PC_LD > PC_INC > hold.
  - PC_LD: PC_COUNT <= mux(PC_MUX_SEL).
  - PC_INC: PC_COUNT <= PC_COUNT+1, modulo 2^ADDR_W (all-ones wraps to 0).
  - PC_LD and PC_INC together: load wins.
- Latency: one clock from input sample to visible PC_COUNT. The mux is combinational.
- SEL=2 with PC_LD samples RAS_TOP before any same-cycle pop. The RET idiom is PC_LD=1, SEL=2, RAS_POP=1 in one cycle.
- SEL=2 with RAS empty loads 0. This alone does not set RAS_UNF.
- RAS is a circular LIFO: top pointer plus count.
  - Push value is PC_COUNT+1 (wrapped) from the current cycle, independent of any same-cycle PC change.
  - Push, not full: count+1, new entry on top.
  - Push, full: oldest entry overwritten, count stays RAS_DEPTH, RAS_OVF set.
  - Pop, not empty: count-1, top moves to the previous entry.
  - Pop, empty: no state change, RAS_UNF set.
  - Push and pop together, count>0: top entry replaced with the push value, count unchanged, no flags.
  - Push and pop together, empty: behaves as push only, and RAS_UNF is set.
- RAS_OVF and RAS_UNF are cleared only by RST.
- Reset during a push/pop cycle: reset wins and the RAS is emptied.

Decomposition:
- Package pc_pkg holds:
  - Enum pc_sel_t: SEL_IMMED=2'd0, SEL_STACK=2'd1, SEL_RAS=2'd2, SEL_INTR=2'd3.
  - Shared default constants for address width and RAS depth.
- Sub-module ras_lifo (parameters ADDR_W, RAS_DEPTH):
  - Holds the storage array, pointer and count logic.
  - Produces RAS_TOP, RAS_COUNT and the flags.
- pc_ras_unit contains the PC register, the next-address mux and the push-value adder, and instantiates ras_lifo.

Test Plan:
1. RST=1 for 1 cycle, then PC_INC=1 for 3 cycles -> PC_COUNT 0,1,2,3; RAS_EMPTY=1, flags 0.
2. PC at 0x3FE, PC_INC=1 for 2 cycles -> 0x3FF then 0x000. Then PC_LD=1 with SEL=0,1,3 (FROM_IMMED=0x0A, FROM_STACK=0x0B) -> 0x00A, 0x00B, 0x3FF. PC_LD=1 with PC_INC=1 and SEL=0 -> 0x00A.
3. CALL/RET: PC=0x010, RAS_PUSH=1 with PC_LD=1, SEL=0, FROM_IMMED=0x080 -> PC=0x080, RAS_TOP=0x011, RAS_COUNT=1. Next, PC_LD=1, SEL=2, RAS_POP=1 -> PC=0x011, RAS_EMPTY=1.
4. RAS_DEPTH=4: push at PC=1..5 (5 pushes) -> RAS_COUNT=4, RAS_FULL=1, RAS_OVF=1. Four pops return tops 0x006,0x005,0x004,0x003 in that order; the 0x002 entry is lost.
5. Pop on empty RAS -> RAS_UNF=1, RAS_COUNT=0, PC unchanged. The flag holds through 10 idle cycles and clears only after RST.
6. RAS holds 0x020, PC=0x030, RAS_PUSH=1 and RAS_POP=1 together -> RAS_TOP=0x031, RAS_COUNT=1, no flags. Same stimulus with RST=1 -> RAS_EMPTY=1 and PC=RST_VAL.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-address-stack block.
// Contents:
//   pc_sel_t           - next-address source select encoding
//   PC_ADDR_W_DEF      - default address-path width
//   PC_RAS_DEPTH_DEF   - default number of return-address entries
package pc_pkg;

    localparam int PC_ADDR_W_DEF    = 10;
    localparam int PC_RAS_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        SEL_IMMED = 2'd0,
        SEL_STACK = 2'd1,
        SEL_RAS   = 2'd2,
        SEL_INTR  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address LIFO: storage array, top pointer and entry count.
// When full, a push overwrites the oldest entry and raises the sticky
// overflow flag; a pop on an empty stack leaves it untouched and raises the
// sticky underflow flag. Both flags clear only on reset.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, pop  - stack strobes (push+pop on a non-empty stack replaces top)
//   push_val   - value written by a push
//   top        - current top entry, 0 when empty
//   count      - number of valid entries
//   empty/full - count == 0 / count == RAS_DEPTH
//   ovf/unf    - sticky overflow / underflow flags
module ras_lifo import pc_pkg::*; #(
    parameter int ADDR_W    = PC_ADDR_W_DEF,
    parameter int RAS_DEPTH = PC_RAS_DEPTH_DEF,
    parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_val,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;      // index of the current top entry
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [CNT_W-1:0]  cnt;
    logic              is_empty;
    logic              is_full;

    // Explicit wrap so depths that are not a power of two stay in range.
    assign ptr_inc  = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
    assign ptr_dec  = (ptr == '0) ? PTR_MAX : ptr - 1'b1;
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push && pop && !is_empty) begin
            mem[ptr] <= push_val;
        end else if (push) begin
            // When full, ptr_inc lands on the oldest entry, overwriting it.
            mem[ptr_inc] <= push_val;
            ptr          <= ptr_inc;
            if (is_full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Reaching here with pop set means the stack was empty.
            if (pop) begin
                unf <= 1'b1;
            end
        end else if (pop) begin
            if (is_empty) begin
                unf <= 1'b1;
            end else begin
                ptr <= ptr_dec;
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign top   = is_empty ? '0 : mem[ptr];
    assign count = cnt;
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-address mux and hardware return-address stack.
// Ports:
//   CLK, RST         - clock, synchronous active-high reset
//   FROM_IMMED       - branch/call target from the instruction
//   FROM_STACK       - address popped from the data-memory stack
//   PC_MUX_SEL       - 0 immediate, 1 stack, 2 RAS top, 3 interrupt vector
//   PC_LD, PC_INC    - load mux output / increment (load has priority)
//   RAS_PUSH         - push PC_COUNT+1 onto the RAS
//   RAS_POP          - pop the RAS
//   PC_COUNT         - registered program counter
//   RAS_TOP          - current RAS top, 0 when empty
//   RAS_COUNT        - valid RAS entries
//   RAS_EMPTY/FULL   - RAS occupancy flags
//   RAS_OVF/UNF      - sticky overflow / underflow flags
module pc_ras_unit import pc_pkg::*; #(
    parameter int                ADDR_W    = PC_ADDR_W_DEF,
    parameter int                RAS_DEPTH = PC_RAS_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] INTR_VEC  = '1,
    parameter logic [ADDR_W-1:0] RST_VAL   = '0,
    parameter int                CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] FROM_IMMED,
    input  logic [ADDR_W-1:0] FROM_STACK,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic              RAS_PUSH,
    input  logic              RAS_POP,
    output logic [ADDR_W-1:0] PC_COUNT,
    output logic [ADDR_W-1:0] RAS_TOP,
    output logic [CNT_W-1:0]  RAS_COUNT,
    output logic              RAS_EMPTY,
    output logic              RAS_FULL,
    output logic              RAS_OVF,
    output logic              RAS_UNF
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] mux_out;

    // Wraps naturally at the address width; shared by increment and push.
    assign pc_plus1 = pc_q + 1'b1;

    // RAS_TOP reflects storage before any same-cycle pop, which makes the
    // single-cycle RET (load from RAS + pop) return the right address.
    always_comb begin
        mux_out = '0;
        case (pc_sel_t'(PC_MUX_SEL))
            SEL_IMMED: mux_out = FROM_IMMED;
            SEL_STACK: mux_out = FROM_STACK;
            SEL_RAS:   mux_out = RAS_TOP;
            SEL_INTR:  mux_out = INTR_VEC;
            default:   mux_out = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= RST_VAL;
        end else if (PC_LD) begin
            pc_q <= mux_out;
        end else if (PC_INC) begin
            pc_q <= pc_plus1;
        end
    end

    assign PC_COUNT = pc_q;

    ras_lifo #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH),
        .CNT_W    (CNT_W)
    ) u_ras (
        .clk     (CLK),
        .rst     (RST),
        .push    (RAS_PUSH),
        .pop     (RAS_POP),
        .push_val(pc_plus1),
        .top     (RAS_TOP),
        .count   (RAS_COUNT),
        .empty   (RAS_EMPTY),
        .full    (RAS_FULL),
        .ovf     (RAS_OVF),
        .unf     (RAS_UNF)
    );

endmodule
